load_store_unit: RTL and testbench

Memory-access initiator for the RISC-V core. It sits between the execute stage and the byte-wide data memory. It takes one load or store request at a time, checks alignment, range and funct3, then runs 1, 2 or 4 sequential byte beats on the data-memory port. For loads it assembles the bytes little-endian and returns a sign- or zero-extended 32-bit result with a one-cycle completion pulse.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/load_store_unit_load_extend.sv | 25 ++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    // Access size in bytes, from the low two funct3 bits
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

    // Returns 1 when the request must be rejected: illegal funct3 for the
    // direction, misaligned halfword/word, or any byte beyond the memory.
    // The last-byte address is formed in 33 bits so it cannot wrap.
    function automatic logic lsu_req_error(
        input logic        write,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [32:0] mem_bytes
    );
        logic        illegal;
        logic        misaligned;
        logic        out_of_range;
        logic [32:0] last_byte;
        if (write) begin
            illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W);
        end else begin
            illegal = (funct3 != F3_B) && (funct3 != F3_H) && (funct3 != F3_W) &&
                      (funct3 != F3_BU) && (funct3 != F3_HU);
        end
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        last_byte    = {1'b0, addr} + {30'd0, lsu_size(funct3)} - 33'd1;
        out_of_range = (last_byte >= mem_bytes);
        return illegal || misaligned || out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of the assembled load bytes according to funct3.
// Latency: combinational.
// Backpressure: none.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    // Select extension mode from the load type
    always_comb begin
        o_data = i_bytes;
        case (i_funct3)
            F3_B:    o_data = {{24{i_bytes[7]}}, i_bytes[7:0]};
            F3_H:    o_data = {{16{i_bytes[15]}}, i_bytes[15:0]};
            F3_W:    o_data = i_bytes;
            F3_BU:   o_data = {24'd0, i_bytes[7:0]};
            F3_HU:   o_data = {16'd0, i_bytes[15:0]};
            default: o_data = i_bytes;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: checks the request, then runs 1/2/4 byte beats.
// Latency: N beat cycles after the start edge, then one DONE cycle; errors finish at once.
// Backpressure: LsuBusy high from the start edge through DONE; starts while busy are dropped.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_BYTES = 128
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LsuStart,
    input  logic        LsuWrite,
    input  logic [2:0]  LsuFunct3,
    input  logic [31:0] LsuAddress,
    input  logic [31:0] LsuStoreData,
    output logic [31:0] LsuLoadData,
    output logic        LsuBusy,
    output logic        LsuDone,
    output logic        LsuError,
    output logic        DmemWriteEnable,
    output logic        DmemReadEnable,
    output logic [31:0] DmemAddress,
    output logic [31:0] DmemWriteData,
    input  logic [31:0] DmemReadData
);

    lsu_state_t  r_state;
    logic        r_write;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [1:0]  r_beat;
    logic [1:0]  r_last_beat;
    logic [31:0] r_asm;
    logic [31:0] r_load_data;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_dmem_we;
    logic        r_dmem_re;
    logic [31:0] r_dmem_addr;
    logic [31:0] r_dmem_wdata;

    logic [2:0]  w_size;
    logic [2:0]  w_last;
    logic        w_req_err;
    logic [1:0]  w_beat_nx;
    logic [31:0] w_nx_addr;
    logic [7:0]  w_nx_byte;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;
    logic        w_unused_rd;

    assign w_size      = lsu_size(LsuFunct3);
    assign w_last      = w_size - 3'd1;
    assign w_req_err   = lsu_req_error(LsuWrite, LsuFunct3, LsuAddress, 33'(DMEM_BYTES));
    assign w_beat_nx   = r_beat + 2'd1;
    assign w_nx_addr   = r_addr + {30'd0, w_beat_nx};
    assign w_nx_byte   = r_sdata[{w_beat_nx, 3'b000} +: 8];
    assign w_unused_rd = &{1'b0, DmemReadData[31:8]};

    // Merge the byte returned this beat into its lane, so the final beat's
    // byte is visible to the extender on the same edge that enters DONE
    always_comb begin
        w_asm_next = r_asm;
        case (r_beat)
            2'd0:    w_asm_next[7:0]   = DmemReadData[7:0];
            2'd1:    w_asm_next[15:8]  = DmemReadData[7:0];
            2'd2:    w_asm_next[23:16] = DmemReadData[7:0];
            default: w_asm_next[31:24] = DmemReadData[7:0];
        endcase
    end

    lsu_load_extend u_extend (
        .i_bytes  (w_asm_next),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    // Request FSM with registered status and data-memory outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_sdata      <= 32'd0;
            r_beat       <= 2'd0;
            r_last_beat  <= 2'd0;
            r_asm        <= 32'd0;
            r_load_data  <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_re    <= 1'b0;
            r_dmem_addr  <= 32'd0;
            r_dmem_wdata <= 32'd0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (LsuStart) begin
                        r_write     <= LsuWrite;
                        r_funct3    <= LsuFunct3;
                        r_addr      <= LsuAddress;
                        r_sdata     <= LsuStoreData;
                        r_beat      <= 2'd0;
                        r_last_beat <= w_last[1:0];
                        r_asm       <= 32'd0;
                        r_busy      <= 1'b1;
                        if (w_req_err) begin
                            // Rejected: report immediately, never touch memory
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else begin
                            // Beat 0 is presented in the very first busy cycle
                            r_state      <= ST_ACCESS;
                            r_dmem_we    <= LsuWrite;
                            r_dmem_re    <= ~LsuWrite;
                            r_dmem_addr  <= LsuAddress;
                            r_dmem_wdata <= LsuWrite ? {24'd0, LsuStoreData[7:0]} : 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!r_write) begin
                        r_asm <= w_asm_next;
                    end
                    if (r_beat == r_last_beat) begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_dmem_we    <= 1'b0;
                        r_dmem_re    <= 1'b0;
                        r_dmem_addr  <= 32'd0;
                        r_dmem_wdata <= 32'd0;
                        if (!r_write) begin
                            r_load_data <= w_ext;
                        end
                    end else begin
                        r_beat       <= w_beat_nx;
                        r_dmem_addr  <= w_nx_addr;
                        r_dmem_wdata <= r_write ? {24'd0, w_nx_byte} : 32'd0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign LsuLoadData     = r_load_data;
    assign LsuBusy         = r_busy;
    assign LsuDone         = r_done;
    assign LsuError        = r_error;
    assign DmemWriteEnable = r_dmem_we;
    assign DmemReadEnable  = r_dmem_re;
    assign DmemAddress     = r_dmem_addr;
    assign DmemWriteData   = r_dmem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-wide behavioural memory.
// Latency: n/a.
// Backpressure: requests issued only when LsuBusy is low.
module tb_load_store_unit;

    localparam int MEMB = 128;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } done_t;

    logic        Clock;
    logic        Reset;
    logic        LsuStart;
    logic        LsuWrite;
    logic [2:0]  LsuFunct3;
    logic [31:0] LsuAddress;
    logic [31:0] LsuStoreData;
    logic [31:0] LsuLoadData;
    logic        LsuBusy;
    logic        LsuDone;
    logic        LsuError;
    logic        DmemWriteEnable;
    logic        DmemReadEnable;
    logic [31:0] DmemAddress;
    logic [31:0] DmemWriteData;
    logic [31:0] DmemReadData;

    logic [7:0]  mem [0:MEMB-1];
    bit          mem_ready = 1'b0;

    beat_t       beat_q[$];
    done_t       done_q[$];
    logic [31:0] last_load;
    int          n_checks = 0;
    int          n_fail   = 0;

    load_store_unit #(.DMEM_BYTES(MEMB)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .LsuStart        (LsuStart),
        .LsuWrite        (LsuWrite),
        .LsuFunct3       (LsuFunct3),
        .LsuAddress      (LsuAddress),
        .LsuStoreData    (LsuStoreData),
        .LsuLoadData     (LsuLoadData),
        .LsuBusy         (LsuBusy),
        .LsuDone         (LsuDone),
        .LsuError        (LsuError),
        .DmemWriteEnable (DmemWriteEnable),
        .DmemReadEnable  (DmemReadEnable),
        .DmemAddress     (DmemAddress),
        .DmemWriteData   (DmemWriteData),
        .DmemReadData    (DmemReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural memory: filled on the first edge, byte writes on strobe
    always @(posedge Clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'h5A ^ 8'(i);
            mem[0] <= 8'h02;
            mem[1] <= 8'h31;
            mem[2] <= 8'h01;
            mem[3] <= 8'h0C;
            mem_ready <= 1'b1;
        end else if (DmemWriteEnable && DmemAddress < MEMB) begin
            mem[DmemAddress[6:0]] <= DmemWriteData[7:0];
        end
    end

    always_comb begin
        DmemReadData = 32'd0;
        if (DmemReadEnable && DmemAddress < MEMB)
            DmemReadData = {24'd0, mem[DmemAddress[6:0]]};
    end

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-cycle monitor: every strobe and every completion is matched to the queues
    always @(negedge Clock) begin
        if (!Reset) begin
            check_val("rd_wr_excl", 96'(DmemReadEnable & DmemWriteEnable), 96'd0);
            check_val("err_wo_done", 96'(LsuError & ~LsuDone), 96'd0);
            if (DmemWriteEnable || DmemReadEnable) begin
                if (beat_q.size() == 0) begin
                    check_val("unexpected_beat", 96'({DmemWriteEnable, DmemReadEnable, DmemAddress}), 96'd0);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check_val("beat", 96'({DmemWriteEnable, DmemReadEnable, DmemAddress, DmemWriteData}), 96'(e));
                end
            end else begin
                check_val("dmem_idle", 96'({DmemAddress, DmemWriteData}), 96'd0);
            end
            if (LsuDone) begin
                if (done_q.size() == 0) begin
                    check_val("unexpected_done", 96'd1, 96'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check_val("done_err", 96'(LsuError), 96'(d.err));
                    check_val("load_data", 96'(LsuLoadData), 96'(d.data));
                end
            end
        end
    end

    task automatic lsu_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sd, input logic exp_err, input logic [31:0] exp_data,
                           input bit noise);
        int    n;
        int    lat;
        beat_t b;
        done_t d;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (!exp_err) begin
            for (int k = 0; k < n; k++) begin
                b.we    = wr;
                b.re    = ~wr;
                b.addr  = addr + 32'(k);
                b.wdata = wr ? ((sd >> (8 * k)) & 32'hFF) : 32'd0;
                beat_q.push_back(b);
            end
        end
        d.err  = exp_err;
        d.data = (exp_err || wr) ? last_load : exp_data;
        last_load = d.data;
        done_q.push_back(d);

        @(negedge Clock);
        check_val("busy_before", 96'(LsuBusy), 96'd0);
        LsuStart     = 1'b1;
        LsuWrite     = wr;
        LsuFunct3    = f3;
        LsuAddress   = addr;
        LsuStoreData = sd;
        @(posedge Clock);
        #1 LsuStart = 1'b0;
        lat = 20;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (i == 0) check_val("busy_during", 96'(LsuBusy), 96'd1);
            if (LsuDone) begin
                lat = i;
                break;
            end
            if (noise) begin
                LsuStart   = 1'b1;
                LsuWrite   = 1'b1;
                LsuFunct3  = 3'b000;
                LsuAddress = 32'd10;
            end
        end
        LsuStart = 1'b0;
        check_val("latency", 96'(lat), 96'(exp_err ? 0 : n));
    endtask

    initial begin
        Reset        = 1'b1;
        LsuStart     = 1'b0;
        LsuWrite     = 1'b0;
        LsuFunct3    = 3'd0;
        LsuAddress   = 32'd0;
        LsuStoreData = 32'd0;
        last_load    = 32'd0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_val("reset_outputs", 96'({LsuLoadData, LsuBusy, LsuDone, LsuError, DmemWriteEnable,
                  DmemReadEnable, DmemAddress, DmemWriteData}), 96'd0);
        Reset = 1'b0;

        // Main loads and stores
        lsu_req(1'b0, 3'b010, 32'd0,  32'd0,        1'b0, 32'h0C013102, 1'b0);
        lsu_req(1'b1, 3'b010, 32'd64, 32'h80FF1234, 1'b0, 32'd0,        1'b0);
        check_val("mem64_67", 96'({mem[67], mem[66], mem[65], mem[64]}), 96'h80FF1234);
        lsu_req(1'b0, 3'b000, 32'd66, 32'd0,        1'b0, 32'hFFFFFFFF, 1'b0);
        lsu_req(1'b0, 3'b100, 32'd66, 32'd0,        1'b0, 32'h000000FF, 1'b0);
        lsu_req(1'b0, 3'b001, 32'd66, 32'd0,        1'b0, 32'hFFFF80FF, 1'b0);
        lsu_req(1'b0, 3'b101, 32'd64, 32'd0,        1'b0, 32'h00001234, 1'b0);

        // Rejected requests: immediate error, no strobes, load data held
        lsu_req(1'b0, 3'b010, 32'd2,   32'd0, 1'b1, 32'd0, 1'b0);
        lsu_req(1'b0, 3'b001, 32'd5,   32'd0, 1'b1, 32'd0, 1'b0);
        lsu_req(1'b0, 3'b010, 32'd126, 32'd0, 1'b1, 32'd0, 1'b0);
        lsu_req(1'b0, 3'b011, 32'd0,   32'd0, 1'b1, 32'd0, 1'b0);
        lsu_req(1'b1, 3'b100, 32'd0,   32'd0, 1'b1, 32'd0, 1'b0);
        // Last byte exactly at the top of memory is legal
        lsu_req(1'b0, 3'b000, 32'd127, 32'd0, 1'b0, 32'h00000025, 1'b0);

        // Reset at the edge ending the second beat of a word store
        beat_q.push_back('{we: 1'b1, re: 1'b0, addr: 32'd68, wdata: 32'hDD});
        beat_q.push_back('{we: 1'b1, re: 1'b0, addr: 32'd69, wdata: 32'hCC});
        @(negedge Clock);
        LsuStart     = 1'b1;
        LsuWrite     = 1'b1;
        LsuFunct3    = 3'b010;
        LsuAddress   = 32'd68;
        LsuStoreData = 32'hAABBCCDD;
        @(posedge Clock);
        #1 LsuStart = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check_val("mid_reset_outputs", 96'({LsuLoadData, LsuBusy, LsuDone, LsuError, DmemWriteEnable,
                  DmemReadEnable, DmemAddress, DmemWriteData}), 96'd0);
        Reset     = 1'b0;
        last_load = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check_val("no_done_after_rst", 96'(LsuDone), 96'd0);
        end
        check_val("mem68_71", 96'({mem[71], mem[70], mem[69], mem[68]}),
                  96'({8'h5A ^ 8'd71, 8'h5A ^ 8'd70, 8'hCC, 8'hDD}));

        // Starts during a load are ignored; next load follows after the idle cycle
        lsu_req(1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 32'h0C013102, 1'b1);
        lsu_req(1'b0, 3'b000, 32'd3, 32'd0, 1'b0, 32'h0000000C, 1'b0);
        check_val("mem10_untouched", 96'(mem[10]), 96'(8'h5A ^ 8'd10));

        repeat (4) @(negedge Clock);
        check_val("beats_left", 96'(beat_q.size()), 96'd0);
        check_val("dones_left", 96'(done_q.size()), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
